// File: rtl/la_fifo_reader.sv
// Read-side engine for the logic-analyser sample FIFO: reads whole bursts with
// unguarded read strobes and serialises each word LSB-byte-first onto a valid/ready stream.
module la_fifo_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int OUT_WIDTH  = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int BURST_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_i,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_dout_i,
    output logic                  fifo_ren_o,
    output logic [ADDR_WIDTH-1:0] fifo_level_o,
    output logic [OUT_WIDTH-1:0]  tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  busy_o,
    output logic [31:0]           word_cnt_o
);

    localparam int NUM_BYTES = DATA_WIDTH / OUT_WIDTH;
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int CNT_W     = ADDR_WIDTH + 1;

    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0]      BURST_FULL = CNT_W'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] LEVEL_NORM = ADDR_WIDTH'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] LEVEL_ZERO = ADDR_WIDTH'(0);
    localparam logic [IDX_W-1:0]      IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0]      IDX_ZERO   = IDX_W'(0);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_RD   = 3'd2,
        S_LAT  = 3'd3,
        S_SEND = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        burst_cnt_q, burst_cnt_d;
    logic [ADDR_WIDTH-1:0]   level_q, level_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]             word_cnt_q, word_cnt_d;

    logic burst_start_s;
    logic level_update_s;
    logic last_hs_s;

    assign burst_start_s  = (state_q == S_WAIT) && enable_i && !fifo_empty_i;
    // The threshold must stay frozen while a burst is outstanding, otherwise the
    // burst length could disagree with the level that released it.
    assign level_update_s = (state_q == S_IDLE) || ((state_q == S_WAIT) && !burst_start_s);
    assign last_hs_s      = (state_q == S_SEND) && tx_ready_i && (byte_idx_q == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable_i) state_d = S_WAIT;
                else          state_d = S_IDLE;
            end
            S_WAIT: begin
                if (!enable_i)         state_d = S_IDLE;
                else if (!fifo_empty_i) state_d = S_RD;
                else                   state_d = S_WAIT;
            end
            S_RD:   state_d = S_LAT;
            S_LAT:  state_d = S_SEND;
            S_SEND: begin
                if (last_hs_s) state_d = (burst_cnt_q != CNT_ZERO) ? S_RD : S_WAIT;
                else           state_d = S_SEND;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: burst counter, level threshold, shifter, counters
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        level_d     = level_q;
        shift_d     = shift_q;
        byte_idx_d  = byte_idx_q;
        word_cnt_d  = word_cnt_q;
        if (level_update_s) level_d = flush_i ? LEVEL_ZERO : LEVEL_NORM;
        else                level_d = level_q;
        case (state_q)
            S_WAIT: begin
                if (burst_start_s) burst_cnt_d = (level_q == LEVEL_ZERO) ? CNT_ONE : BURST_FULL;
                else               burst_cnt_d = burst_cnt_q;
            end
            S_RD: burst_cnt_d = burst_cnt_q - CNT_ONE;
            S_LAT: begin
                shift_d    = fifo_dout_i;
                byte_idx_d = IDX_ZERO;
            end
            S_SEND: begin
                if (tx_ready_i) begin
                    shift_d    = shift_q >> OUT_WIDTH;
                    byte_idx_d = byte_idx_q + IDX_ONE;
                    if (byte_idx_q == LAST_IDX) word_cnt_d = word_cnt_q + 32'd1;
                    else                        word_cnt_d = word_cnt_q;
                end else begin
                    shift_d = shift_q;
                end
            end
            default: shift_d = shift_q;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt_q <= CNT_ZERO;
            level_q     <= LEVEL_NORM;
            shift_q     <= {DATA_WIDTH{1'b0}};
            byte_idx_q  <= IDX_ZERO;
            word_cnt_q  <= 32'd0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            level_q     <= level_d;
            shift_q     <= shift_d;
            byte_idx_q  <= byte_idx_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    // Output decode straight from registers, so no input-to-output paths
    always_comb begin
        fifo_ren_o   = (state_q == S_RD);
        tx_valid_o   = (state_q == S_SEND);
        busy_o       = (state_q != S_IDLE);
        tx_data_o    = shift_q[OUT_WIDTH-1:0];
        fifo_level_o = level_q;
        word_cnt_o   = word_cnt_q;
    end

endmodule

// File: tb/tb_la_fifo_reader.sv
// Directed bench for la_fifo_reader: a behavioural FIFO with level-based empty,
// a table of burst scenarios, and hand-written multi-cycle corner cases.
module tb_la_fifo_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        flush;
    logic        fifo_empty;
    logic [63:0] fifo_dout;
    logic        fifo_ren;
    logic [11:0] fifo_level;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [31:0] word_cnt;

    la_fifo_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable),
        .flush_i      (flush),
        .fifo_empty_i (fifo_empty),
        .fifo_dout_i  (fifo_dout),
        .fifo_ren_o   (fifo_ren),
        .fifo_level_o (fifo_level),
        .tx_data_o    (tx_data),
        .tx_valid_o   (tx_valid),
        .tx_ready_i   (tx_ready),
        .busy_o       (busy),
        .word_cnt_o   (word_cnt)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [0:4095];
    logic [7:0]  rx_mem [0:8191];
    int wr_cnt = 0;
    int rd_cnt;
    int occ;
    int overrd;
    int ren_cnt;
    int rx_cnt;
    int n_pass = 0;
    int n_total = 0;

    assign occ        = wr_cnt - rd_cnt;
    assign fifo_empty = (occ <= int'(fifo_level));

    // FIFO model: registered read data, reset empties it, reads on empty are counted
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt    <= wr_cnt;
            fifo_dout <= 64'd0;
            overrd    <= overrd;
        end else if (fifo_ren) begin
            if (wr_cnt == rd_cnt) begin
                overrd <= overrd + 1;
            end else begin
                fifo_dout <= mem[rd_cnt % 4096];
                rd_cnt    <= rd_cnt + 1;
            end
        end
    end

    // Stream monitor
    always @(posedge clk) begin
        if (fifo_ren) ren_cnt <= ren_cnt + 1;
        if (tx_valid && tx_ready) begin
            rx_mem[rx_cnt % 8192] <= tx_data;
            rx_cnt <= rx_cnt + 1;
        end
    end

    initial begin
        overrd  = 0;
        ren_cnt = 0;
        rx_cnt  = 0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_cnt % 4096] = 64'h0706050403020100 + 64'(wr_cnt % 256);
            wr_cnt++;
        end
    endtask

    task automatic data_check(input string name, input int rx0, input int rd0, input int nbytes);
        int bad = 0;
        logic [63:0] w;
        for (int k = 0; k < nbytes; k++) begin
            w = mem[(rd0 + k / 8) % 4096];
            if (rx_mem[(rx0 + k) % 8192] !== w[8 * (k % 8) +: 8]) bad++;
        end
        check(name, 64'(bad), 64'd0);
    endtask

    typedef struct {
        int   n_push;
        logic flush;
        int   cycles;
        int   exp_ren;
        int   exp_words;
        int   exp_occ;
        int   exp_level;
    } vec_t;

    vec_t vecs [6];
    int ren0, rx0, rd0, stall_bad, lvl_bad;
    logic [31:0] wc0;

    initial begin
        vecs[0] = '{15, 1'b0, 200,  0,  0, 15, 15};
        vecs[1] = '{ 0, 1'b1, 200, 15, 15,  0,  0};
        vecs[2] = '{20, 1'b0, 250, 16, 16,  4, 15};
        vecs[3] = '{ 0, 1'b1, 100,  4,  4,  0,  0};
        vecs[4] = '{33, 1'b0, 400, 32, 32,  1, 15};
        vecs[5] = '{ 0, 1'b1,  50,  1,  1,  0,  0};

        rst_n = 1'b0; enable = 1'b0; flush = 1'b0; tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ren",   64'(fifo_ren),   64'd0);
        check("rst_valid", 64'(tx_valid),   64'd0);
        check("rst_data",  64'(tx_data),    64'd0);
        check("rst_busy",  64'(busy),       64'd0);
        check("rst_wcnt",  64'(word_cnt),   64'd0);
        check("rst_level", 64'(fifo_level), 64'd15);
        rst_n = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("wait_busy", 64'(busy), 64'd1);

        // Normal burst with latency checks
        ren0 = ren_cnt; rx0 = rx_cnt; rd0 = rd_cnt; wc0 = word_cnt;
        push(16);
        #1;
        check("lat_empty_fall", 64'(fifo_empty), 64'd0);
        check("lat_ren_t0",     64'(fifo_ren),   64'd0);
        @(negedge clk);
        check("lat_ren_t1",     64'(fifo_ren),   64'd1);
        @(negedge clk);
        check("lat_ren_t2",     64'(fifo_ren),   64'd0);
        check("lat_valid_t2",   64'(tx_valid),   64'd0);
        @(negedge clk);
        check("lat_valid_t3",   64'(tx_valid),   64'd1);
        check("lat_byte0",      64'(tx_data),    64'h00);
        repeat (200) @(negedge clk);
        check("norm_ren",   64'(ren_cnt - ren0),   64'd16);
        check("norm_bytes", 64'(rx_cnt - rx0),     64'd128);
        check("norm_wcnt",  64'(word_cnt - wc0),   64'd16);
        check("norm_occ",   64'(occ),              64'd0);
        data_check("norm_data", rx0, rd0, 128);

        // Table-driven burst scenarios
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            ren0 = ren_cnt; rx0 = rx_cnt; rd0 = rd_cnt; wc0 = word_cnt;
            flush = vecs[v].flush;
            @(negedge clk);
            check($sformatf("v%0d_level_next", v), 64'(fifo_level), 64'(vecs[v].exp_level));
            @(negedge clk);
            push(vecs[v].n_push);
            repeat (vecs[v].cycles) @(negedge clk);
            check($sformatf("v%0d_ren", v),   64'(ren_cnt - ren0),  64'(vecs[v].exp_ren));
            check($sformatf("v%0d_words", v), 64'(word_cnt - wc0),  64'(vecs[v].exp_words));
            check($sformatf("v%0d_bytes", v), 64'(rx_cnt - rx0),    64'(vecs[v].exp_words * 8));
            check($sformatf("v%0d_occ", v),   64'(occ),             64'(vecs[v].exp_occ));
            check($sformatf("v%0d_level", v), 64'(fifo_level),      64'(vecs[v].exp_level));
            check($sformatf("v%0d_busy", v),  64'(busy),            64'd1);
            data_check($sformatf("v%0d_data", v), rx0, rd0, vecs[v].exp_words * 8);
        end
        flush = 1'b0;
        repeat (3) @(negedge clk);

        // Back-pressure at byte 3 of the first word
        ren0 = ren_cnt; rx0 = rx_cnt; rd0 = rd_cnt; wc0 = word_cnt;
        push(16);
        for (int i = 0; i < 100 && !(tx_valid && (rx_cnt - rx0) == 3); i++) @(negedge clk);
        check("bp_reach", 64'(tx_valid && (rx_cnt - rx0) == 3), 64'd1);
        check("bp_byte3", 64'(tx_data), 64'h03);
        tx_ready = 1'b0;
        ren0 = ren_cnt;
        stall_bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!tx_valid || tx_data !== 8'h03) stall_bad++;
        end
        check("bp_stable", 64'(stall_bad), 64'd0);
        check("bp_no_ren", 64'(ren_cnt - ren0), 64'd0);
        tx_ready = 1'b1;
        @(negedge clk);
        check("bp_resume", 64'(tx_data), 64'h04);
        repeat (250) @(negedge clk);
        check("bp_words", 64'(word_cnt - wc0), 64'd16);
        data_check("bp_data", rx0, rd0, 128);

        // Disable after five words of a burst
        ren0 = ren_cnt; rx0 = rx_cnt; rd0 = rd_cnt; wc0 = word_cnt;
        push(48);
        for (int i = 0; i < 400 && (word_cnt - wc0) < 5; i++) @(negedge clk);
        check("dis_reach", 64'((word_cnt - wc0) == 5), 64'd1);
        enable = 1'b0;
        repeat (300) @(negedge clk);
        check("dis_words", 64'(word_cnt - wc0), 64'd16);
        check("dis_ren",   64'(ren_cnt - ren0), 64'd16);
        check("dis_busy",  64'(busy),           64'd0);
        check("dis_occ",   64'(occ),            64'd32);
        repeat (100) @(negedge clk);
        check("dis_no_ren", 64'(ren_cnt - ren0), 64'd16);
        enable = 1'b1;
        repeat (500) @(negedge clk);
        check("dis_drain_occ", 64'(occ), 64'd0);
        data_check("dis_data", rx0, rd0, 48 * 8);

        // Flush raised during word 2 of a normal burst
        ren0 = ren_cnt; wc0 = word_cnt;
        push(16);
        for (int i = 0; i < 100 && (word_cnt - wc0) < 2; i++) @(negedge clk);
        check("fl_reach", 64'((word_cnt - wc0) == 2), 64'd1);
        flush = 1'b1;
        lvl_bad = 0;
        for (int i = 0; i < 300 && (word_cnt - wc0) < 16; i++) begin
            @(negedge clk);
            if (fifo_level !== 12'd15) lvl_bad++;
        end
        check("fl_level_held", 64'(lvl_bad), 64'd0);
        check("fl_ren",        64'(ren_cnt - ren0), 64'd16);
        @(negedge clk);
        check("fl_level_next", 64'(fifo_level), 64'd0);
        flush = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset during word 7
        wc0 = word_cnt;
        push(16);
        for (int i = 0; i < 200 && !((word_cnt - wc0) == 7 && tx_valid); i++) @(negedge clk);
        check("rst_reach", 64'((word_cnt - wc0) == 7 && tx_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(tx_valid),   64'd0);
        check("arst_ren",   64'(fifo_ren),   64'd0);
        check("arst_wcnt",  64'(word_cnt),   64'd0);
        check("arst_level", 64'(fifo_level), 64'd15);
        check("arst_busy",  64'(busy),       64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        ren0 = ren_cnt; rx0 = rx_cnt; rd0 = rd_cnt;
        push(16);
        repeat (250) @(negedge clk);
        check("rr_wcnt", 64'(word_cnt), 64'd16);
        check("rr_ren",  64'(ren_cnt - ren0), 64'd16);
        data_check("rr_data", rx0, rd0, 128);

        check("no_overread", 64'(overrd), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
